// File: rtl/esfa_result_checker.sv
// Result scoreboard for the ESFA core: aligns issued assertion fields with the
// core's delayed results, keeps pass/fail statistics and drives program status.
module esfa_result_checker #(
  parameter int RESULT_LATENCY = 1,   // legal range 1..4
  parameter bit STOP_ON_FAIL   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_index,
  input  logic       in_assert,
  input  logic       in_expectedBool,
  input  logic [7:0] in_expectedValue,
  input  logic       in_last,
  input  logic       resultBool,
  input  logic [7:0] resultValue,
  output logic       programIsRunning,
  output logic       programIsCorrect,
  output logic       done,
  output logic [7:0] pass_count,
  output logic [7:0] fail_count,
  output logic [7:0] first_fail_index,
  output logic [7:0] first_fail_got,
  output logic [1:0] dbgState
);

  // Issue handshake: in_valid is a one-way strobe with no ready; it is accepted
  // only while programIsRunning is high, and anything issued later is dropped.
  localparam int TAIL = RESULT_LATENCY - 1;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    PASS_DONE = 2'd1,
    FAIL_HALT = 2'd2
  } state_t;

  state_t state, stateNext;

  logic [RESULT_LATENCY-1:0] pipeValid;
  logic [RESULT_LATENCY-1:0] pipeAssert;
  logic [RESULT_LATENCY-1:0] pipeExpB;
  logic [RESULT_LATENCY-1:0] pipeLast;
  logic [7:0]                pipeIndex [RESULT_LATENCY];
  logic [7:0]                pipeExpV  [RESULT_LATENCY];

  logic tailValid;
  logic tailCheck;
  logic valueOk;
  logic checkPass;
  logic checkFail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipeValid  <= '0;
      pipeAssert <= '0;
      pipeExpB   <= '0;
      pipeLast   <= '0;
      for (int i = 0; i < RESULT_LATENCY; i++) begin
        pipeIndex[i] <= '0;
        pipeExpV[i]  <= '0;
      end
    end else begin
      pipeValid[0]  <= in_valid && (state == RUN);
      pipeAssert[0] <= in_assert;
      pipeExpB[0]   <= in_expectedBool;
      pipeLast[0]   <= in_last;
      pipeIndex[0]  <= in_index;
      pipeExpV[0]   <= in_expectedValue;
      for (int i = 1; i < RESULT_LATENCY; i++) begin
        pipeValid[i]  <= pipeValid[i-1];
        pipeAssert[i] <= pipeAssert[i-1];
        pipeExpB[i]   <= pipeExpB[i-1];
        pipeLast[i]   <= pipeLast[i-1];
        pipeIndex[i]  <= pipeIndex[i-1];
        pipeExpV[i]   <= pipeExpV[i-1];
      end
    end
  end

  // Gating on RUN discards in-flight entries once a terminal state is reached.
  assign tailValid = pipeValid[TAIL] && (state == RUN);
  assign tailCheck = tailValid && pipeAssert[TAIL];
  assign valueOk   = !pipeExpB[TAIL] || (resultValue == pipeExpV[TAIL]);
  assign checkPass = tailCheck && (resultBool == pipeExpB[TAIL]) && valueOk;
  assign checkFail = tailCheck && !((resultBool == pipeExpB[TAIL]) && valueOk);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN: begin
        if (checkFail && STOP_ON_FAIL)          stateNext = FAIL_HALT;
        else if (tailValid && pipeLast[TAIL])   stateNext = PASS_DONE;
      end
      default: stateNext = state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      programIsCorrect <= 1'b1;
      pass_count       <= '0;
      fail_count       <= '0;
      first_fail_index <= '0;
      first_fail_got   <= '0;
    end else begin
      if (checkPass && (pass_count != 8'hFF)) pass_count <= pass_count + 8'd1;
      if (checkFail) begin
        if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
        programIsCorrect <= 1'b0;
        // programIsCorrect still high means no earlier failure was captured.
        if (programIsCorrect) begin
          first_fail_index <= pipeIndex[TAIL];
          first_fail_got   <= resultValue;
        end
      end
    end
  end

  assign programIsRunning = (state == RUN);
  assign done             = (state != RUN);
  assign dbgState         = state;

endmodule

// File: tb/tb_esfa_result_checker.sv
// Bench for esfa_result_checker: three instances (L=1 stop, L=2 stop, L=3 continue)
// driven from one stimulus thread, scored against a transaction-level model.
module tb_esfa_result_checker;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst     [N];
  logic       inValid [N];
  logic [7:0] inIndex [N];
  logic       inAssert[N];
  logic       inExpB  [N];
  logic [7:0] inExpV  [N];
  logic       inLast  [N];
  logic       resB    [N];
  logic [7:0] resV    [N];
  logic       running [N];
  logic       correct [N];
  logic       doneO   [N];
  logic [7:0] passCnt [N];
  logic [7:0] failCnt [N];
  logic [7:0] ffIdx   [N];
  logic [7:0] ffGot   [N];
  logic [1:0] dbg     [N];

  function automatic int lat_of(input int g);
    return g + 1;
  endfunction

  function automatic bit stop_of(input int g);
    return g != 2;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    esfa_result_checker #(
      .RESULT_LATENCY(g + 1),
      .STOP_ON_FAIL  (g != 2)
    ) dut (
      .clk             (clk),
      .rst             (rst[g]),
      .in_valid        (inValid[g]),
      .in_index        (inIndex[g]),
      .in_assert       (inAssert[g]),
      .in_expectedBool (inExpB[g]),
      .in_expectedValue(inExpV[g]),
      .in_last         (inLast[g]),
      .resultBool      (resB[g]),
      .resultValue     (resV[g]),
      .programIsRunning(running[g]),
      .programIsCorrect(correct[g]),
      .done            (doneO[g]),
      .pass_count      (passCnt[g]),
      .fail_count      (failCnt[g]),
      .first_fail_index(ffIdx[g]),
      .first_fail_got  (ffGot[g]),
      .dbgState        (dbg[g])
    );
  end

  // Behavioural core: result of an instruction appears L cycles after issue.
  logic       corePB [N][5];
  logic [7:0] corePV [N][5];

  int mPass [N];
  int mFail [N];
  bit mCorrect [N];
  int mState [N];   // 0 run, 1 pass-done, 2 fail-halt
  int mFfIdx [N];
  int mFfGot [N];

  typedef struct packed {
    logic [15:0] issue;
    logic [1:0]  g;
    logic        chk;
    logic        pass;
    logic        last;
    logic [7:0]  idx;
    logic [7:0]  got;
  } ent_t;
  localparam int W = $bits(ent_t);
  logic [W-1:0] issue_q[$];
  logic [W-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int g);
    mPass[g] = 0; mFail[g] = 0; mCorrect[g] = 1'b1;
    mState[g] = 0; mFfIdx[g] = 0; mFfGot[g] = 0;
  endtask

  task automatic apply(input ent_t e);
    int g;
    bit fail;
    g = int'(e.g);
    if (mState[g] != 0) return;
    fail = e.chk && !e.pass;
    if (e.chk && e.pass && mPass[g] < 255) mPass[g]++;
    if (fail) begin
      if (mFail[g] < 255) mFail[g]++;
      if (mCorrect[g]) begin
        mFfIdx[g] = int'(e.idx);
        mFfGot[g] = int'(e.got);
      end
      mCorrect[g] = 1'b0;
    end
    if (fail && stop_of(g)) mState[g] = 2;
    else if (e.last)        mState[g] = 1;
  endtask

  // Scoreboard: retire entries due at this edge, then admit this edge's issues.
  always @(negedge clk) begin : mon
    bit pre [N];
    logic [W-1:0] keep[$];
    ent_t e;
    for (int g = 0; g < N; g++) pre[g] = (mState[g] == 0);
    keep.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      if (int'(e.issue) + lat_of(int'(e.g)) == cyc) apply(e);
      else keep.push_back(exp_q[i]);
    end
    exp_q = keep;
    keep.delete();
    for (int i = 0; i < issue_q.size(); i++) begin
      e = issue_q[i];
      if (int'(e.issue) == cyc) begin
        if (pre[int'(e.g)] && !rst[int'(e.g)]) exp_q.push_back(issue_q[i]);
      end else keep.push_back(issue_q[i]);
    end
    issue_q = keep;
    for (int g = 0; g < N; g++) begin
      if (rst[g]) model_reset(g);
      check_eq($sformatf("u%0d.running", g), 32'(running[g]), 32'(mState[g] == 0));
      check_eq($sformatf("u%0d.done", g),    32'(doneO[g]),   32'(mState[g] != 0));
      check_eq($sformatf("u%0d.state", g),   32'(dbg[g]),     32'(mState[g]));
      check_eq($sformatf("u%0d.correct", g), 32'(correct[g]), 32'(mCorrect[g]));
      check_eq($sformatf("u%0d.pass", g),    32'(passCnt[g]), 32'(mPass[g]));
      check_eq($sformatf("u%0d.fail", g),    32'(failCnt[g]), 32'(mFail[g]));
      check_eq($sformatf("u%0d.ffidx", g),   32'(ffIdx[g]),   32'(mFfIdx[g]));
      check_eq($sformatf("u%0d.ffgot", g),   32'(ffGot[g]),   32'(mFfGot[g]));
    end
  end

  task automatic tick(input int g, input bit v, input logic [7:0] idx, input bit a,
                      input bit eb, input logic [7:0] ev, input bit last,
                      input bit gb, input logic [7:0] gv);
    ent_t e;
    @(posedge clk);
    #1;
    for (int h = 0; h < N; h++) begin
      for (int s = 4; s > 0; s--) begin
        corePB[h][s] = corePB[h][s-1];
        corePV[h][s] = corePV[h][s-1];
      end
      corePB[h][0] = 1'($urandom_range(0, 1));
      corePV[h][0] = 8'($urandom_range(0, 255));
      inValid[h]  = 1'b0;
      inIndex[h]  = 8'($urandom_range(0, 255));
      inAssert[h] = 1'($urandom_range(0, 1));
      inExpB[h]   = 1'($urandom_range(0, 1));
      inExpV[h]   = 8'($urandom_range(0, 255));
      inLast[h]   = 1'($urandom_range(0, 1));
    end
    if (v) begin
      corePB[g][0] = gb; corePV[g][0] = gv;
      inValid[g] = 1'b1; inIndex[g] = idx; inAssert[g] = a;
      inExpB[g] = eb; inExpV[g] = ev; inLast[g] = last;
      e.issue = 16'(cyc + 1);
      e.g     = 2'(g);
      e.chk   = a;
      e.pass  = (gb == eb) && (!eb || gv == ev);
      e.last  = last;
      e.idx   = idx;
      e.got   = gv;
      issue_q.push_back(e);
    end
    for (int h = 0; h < N; h++) begin
      resB[h] = corePB[h][lat_of(h)];
      resV[h] = corePV[h][lat_of(h)];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 1'b0, 8'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 8'h0);
  endtask

  task automatic iss(input int g, input logic [7:0] idx, input bit a, input bit eb,
                     input logic [7:0] ev, input bit last, input bit gb, input logic [7:0] gv);
    tick(g, 1'b1, idx, a, eb, ev, last, gb, gv);
  endtask

  task automatic iss_ok(input int g, input logic [7:0] idx, input bit last);
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    iss(g, idx, 1'b1, 1'b1, v, last, 1'b1, v);
  endtask

  task automatic do_reset(input int g);
    @(posedge clk);
    #3;
    rst[g] = 1'b1;
    inValid[g] = 1'b0;
    #1;
    check_eq("rst.running", 32'(running[g]), 32'd1);
    check_eq("rst.done",    32'(doneO[g]),   32'd0);
    check_eq("rst.correct", 32'(correct[g]), 32'd1);
    check_eq("rst.pass",    32'(passCnt[g]), 32'd0);
    check_eq("rst.fail",    32'(failCnt[g]), 32'd0);
    check_eq("rst.ffidx",   32'(ffIdx[g]),   32'd0);
    check_eq("rst.ffgot",   32'(ffGot[g]),   32'd0);
    issue_q.delete();
    exp_q.delete();
    model_reset(g);
    @(posedge clk);
    #1;
    rst[g] = 1'b0;
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int h = 0; h < N; h++) begin
      rst[h] = 1'b1; inValid[h] = 1'b0; inIndex[h] = '0; inAssert[h] = 1'b0;
      inExpB[h] = 1'b0; inExpV[h] = '0; inLast[h] = 1'b0; resB[h] = 1'b0; resV[h] = '0;
      for (int s = 0; s < 5; s++) begin corePB[h][s] = 1'b0; corePV[h][s] = '0; end
      model_reset(h);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int h = 0; h < N; h++) rst[h] = 1'b0;

    // L=1: four matching checks, last on index 3
    for (int i = 0; i < 4; i++) iss_ok(0, 8'(i), i == 3);
    idle(3);
    check_eq("a.pass",    32'(passCnt[0]), 32'd4);
    check_eq("a.fail",    32'(failCnt[0]), 32'd0);
    check_eq("a.done",    32'(doneO[0]),   32'd1);
    check_eq("a.correct", 32'(correct[0]), 32'd1);
    check_eq("a.running", 32'(running[0]), 32'd0);

    // value ignored when expB=0; unasserted mismatch changes nothing
    do_reset(0);
    iss(0, 8'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFF);
    iss(0, 8'd1, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h33);
    iss(0, 8'd2, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 8'h77);
    idle(3);
    check_eq("c.pass",    32'(passCnt[0]), 32'd2);
    check_eq("c.fail",    32'(failCnt[0]), 32'd0);
    check_eq("c.correct", 32'(correct[0]), 32'd1);
    check_eq("c.state",   32'(dbg[0]),     32'd1);

    // saturation of pass_count
    do_reset(0);
    for (int i = 0; i < 300; i++) iss_ok(0, 8'(i), i == 299);
    idle(3);
    check_eq("f.pass", 32'(passCnt[0]), 32'd255);
    check_eq("f.done", 32'(doneO[0]),   32'd1);

    // L=2: mismatch at index 2 halts with index 3 already in flight
    iss_ok(1, 8'd0, 1'b0);
    iss_ok(1, 8'd1, 1'b0);
    iss(1, 8'd2, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 8'h5B);
    iss_ok(1, 8'd3, 1'b1);
    iss_ok(1, 8'd4, 1'b0);
    idle(4);
    check_eq("b.fail",  32'(failCnt[1]), 32'd1);
    check_eq("b.pass",  32'(passCnt[1]), 32'd2);
    check_eq("b.ffidx", 32'(ffIdx[1]),   32'd2);
    check_eq("b.ffgot", 32'(ffGot[1]),   32'h5B);
    check_eq("b.state", 32'(dbg[1]),     32'd2);

    // last entry fails with stop-on-fail
    do_reset(1);
    iss_ok(1, 8'd0, 1'b0);
    iss(1, 8'd1, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 8'h10);
    idle(4);
    check_eq("e.fail",  32'(failCnt[1]), 32'd1);
    check_eq("e.done",  32'(doneO[1]),   32'd1);
    check_eq("e.state", 32'(dbg[1]),     32'd2);

    // reset mid-program with entries in flight, then a clean short program
    do_reset(1);
    for (int i = 0; i < 3; i++) iss_ok(1, 8'(i), 1'b0);
    do_reset(1);
    iss_ok(1, 8'd0, 1'b0);
    iss_ok(1, 8'd1, 1'b1);
    idle(4);
    check_eq("g.pass",  32'(passCnt[1]), 32'd2);
    check_eq("g.fail",  32'(failCnt[1]), 32'd0);
    check_eq("g.state", 32'(dbg[1]),     32'd1);

    // L=3, continue on fail: failures at 1 and 4, last at 5
    iss_ok(2, 8'd0, 1'b0);
    iss(2, 8'd1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hC3);
    iss_ok(2, 8'd2, 1'b0);
    iss_ok(2, 8'd3, 1'b0);
    iss(2, 8'd4, 1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 8'h21);
    iss_ok(2, 8'd5, 1'b1);
    idle(5);
    check_eq("d.fail",    32'(failCnt[2]), 32'd2);
    check_eq("d.pass",    32'(passCnt[2]), 32'd4);
    check_eq("d.ffidx",   32'(ffIdx[2]),   32'd1);
    check_eq("d.ffgot",   32'(ffGot[2]),   32'hC3);
    check_eq("d.correct", 32'(correct[2]), 32'd0);
    check_eq("d.done",    32'(doneO[2]),   32'd1);
    check_eq("d.state",   32'(dbg[2]),     32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
